// File: rtl/rsi_pkg.sv
// Shared types and constants for the RSI threshold detector.
// Holds the detector state encoding and the default threshold settings.
package rsi_pkg;

    typedef enum logic [1:0] {
        NEUTRAL    = 2'd0,
        OVERSOLD   = 2'd1,
        OVERBOUGHT = 2'd2
    } rsi_state_t;

    localparam int unsigned RSI_MAX        = 100;
    localparam int unsigned WIDTH_DEF      = 32;
    localparam int unsigned LOW_TH_DEF     = 30;
    localparam int unsigned HIGH_TH_DEF    = 70;
    localparam int unsigned HYST_DEF       = 2;
    localparam int unsigned CONFIRM_DEF    = 1;

endpackage

// File: rtl/rsi_persist.sv
// Saturating consecutive-condition counter.
// ok is high when the counter's next value reaches CONFIRM, so a flag can follow on the same edge.
module rsi_persist #(
    parameter int unsigned CONFIRM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cond,
    output logic ok
);

    localparam int unsigned CW = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
    localparam logic [CW-1:0] C_SAT = CW'(CONFIRM);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = '0;
        if (cond) begin
            w_cnt_next = (r_cnt == C_SAT) ? C_SAT : r_cnt + CW'(1);
        end
    end

    assign ok = (w_cnt_next == C_SAT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/rsi_signal.sv
// RSI threshold detector: clamps the sample to 0..100, filters entry with
// persistence counters, applies exit hysteresis and drives registered buy/sell flags.
module rsi_signal
    import rsi_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned LOW_TH  = LOW_TH_DEF,
    parameter int unsigned HIGH_TH = HIGH_TH_DEF,
    parameter int unsigned HYST    = HYST_DEF,
    parameter int unsigned CONFIRM = CONFIRM_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] RSI,
    output logic             out1,
    output logic             out2
);

    if (LOW_TH + HYST > HIGH_TH - HYST || HYST > HIGH_TH) begin : g_bad_band
        $error("rsi_signal: LOW_TH+HYST must not exceed HIGH_TH-HYST");
    end
    if (HIGH_TH > RSI_MAX) begin : g_bad_high
        $error("rsi_signal: HIGH_TH must not exceed 100");
    end
    if (CONFIRM < 1) begin : g_bad_confirm
        $error("rsi_signal: CONFIRM must be at least 1");
    end
    if (WIDTH < 7) begin : g_bad_width
        $error("rsi_signal: WIDTH must hold the value 100");
    end

    localparam logic [WIDTH-1:0] C_MAX      = WIDTH'(RSI_MAX);
    localparam logic [WIDTH-1:0] C_LOW      = WIDTH'(LOW_TH);
    localparam logic [WIDTH-1:0] C_HIGH     = WIDTH'(HIGH_TH);
    localparam logic [WIDTH-1:0] C_LOW_EXIT = WIDTH'(LOW_TH + HYST);
    localparam logic [WIDTH-1:0] C_HI_EXIT  = WIDTH'(HIGH_TH - HYST);

    logic [WIDTH-1:0] w_r;
    logic             w_lo_cond;
    logic             w_hi_cond;
    logic             w_lo_ok;
    logic             w_hi_ok;
    rsi_state_t       r_state;
    rsi_state_t       w_state_next;
    logic             r_out1;
    logic             r_out2;

    assign w_r       = (RSI > C_MAX) ? C_MAX : RSI;
    assign w_lo_cond = (w_r < C_LOW);
    assign w_hi_cond = (w_r > C_HIGH);

    rsi_persist #(.CONFIRM(CONFIRM)) u_persist_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .cond  (w_lo_cond),
        .ok    (w_lo_ok)
    );

    rsi_persist #(.CONFIRM(CONFIRM)) u_persist_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .cond  (w_hi_cond),
        .ok    (w_hi_ok)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            NEUTRAL: begin
                if (w_lo_ok)      w_state_next = OVERSOLD;
                else if (w_hi_ok) w_state_next = OVERBOUGHT;
            end
            OVERSOLD: begin
                if (w_hi_ok)                 w_state_next = OVERBOUGHT;
                else if (w_r >= C_LOW_EXIT)  w_state_next = NEUTRAL;
            end
            OVERBOUGHT: begin
                if (w_lo_ok)                 w_state_next = OVERSOLD;
                else if (w_r <= C_HI_EXIT)   w_state_next = NEUTRAL;
            end
            default: w_state_next = NEUTRAL;
        endcase
    end

    // Flags are decoded from the next state and registered alongside it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= NEUTRAL;
            r_out1  <= 1'b0;
            r_out2  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_out1  <= (w_state_next == OVERSOLD);
            r_out2  <= (w_state_next == OVERBOUGHT);
        end
    end

    assign out1 = r_out1;
    assign out2 = r_out2;

endmodule

// File: tb/tb_rsi_signal.sv
// Directed bench for rsi_signal: one instance with CONFIRM=1, one with CONFIRM=3.
// Expected flag pairs {out1,out2} are hand-computed per step.
module tb_rsi_signal;

    logic        clk;
    logic        rst_n_a;
    logic        rst_n_b;
    logic [31:0] rsi_a;
    logic [31:0] rsi_b;
    logic        out1_a, out2_a;
    logic        out1_b, out2_b;

    int n_checks;
    int n_fail;

    rsi_signal #(.CONFIRM(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .RSI   (rsi_a),
        .out1  (out1_a),
        .out2  (out2_a)
    );

    rsi_signal #(.CONFIRM(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .RSI   (rsi_b),
        .out1  (out1_b),
        .out2  (out2_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {out1,out2}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic step_a(input logic [31:0] v, input logic rst, input logic [1:0] exp, input string tag);
        rsi_a   = v;
        rst_n_a = rst;
        @(posedge clk);
        #1;
        check_eq(tag, {out1_a, out2_a}, exp);
    endtask

    task automatic step_b(input logic [31:0] v, input logic rst, input logic [1:0] exp, input string tag);
        rsi_b   = v;
        rst_n_b = rst;
        @(posedge clk);
        #1;
        check_eq(tag, {out1_b, out2_b}, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n_a  = 1'b0;
        rst_n_b  = 1'b0;
        rsi_a    = 32'd10;
        rsi_b    = 32'd10;

        // Reset and release, CONFIRM=1
        step_a(32'd10, 1'b0, 2'b00, "rst_edge1");
        step_a(32'd10, 1'b0, 2'b00, "rst_edge2");
        step_a(32'd10, 1'b1, 2'b10, "rst_release");

        // Threshold walk
        step_a(32'd29, 1'b1, 2'b10, "th_29");
        step_a(32'd30, 1'b1, 2'b10, "th_30_hold");
        step_a(32'd50, 1'b1, 2'b00, "th_50");
        step_a(32'd70, 1'b1, 2'b00, "th_70_not_ob");
        step_a(32'd71, 1'b1, 2'b01, "th_71");

        // Hysteresis
        step_a(32'd69, 1'b1, 2'b01, "hy_69_hold");
        step_a(32'd68, 1'b1, 2'b00, "hy_68_exit");
        step_a(32'd20, 1'b1, 2'b10, "hy_20_enter");
        step_a(32'd31, 1'b1, 2'b10, "hy_31_hold");
        step_a(32'd32, 1'b1, 2'b00, "hy_32_exit");

        // Swing and clamp
        step_a(32'd5,          1'b1, 2'b10, "sw_5");
        step_a(32'hFFFF_FFFF,  1'b1, 2'b01, "sw_ffffffff");
        step_a(32'd50,         1'b1, 2'b00, "sw_50");
        step_a(32'd101,        1'b1, 2'b01, "clamp_101");
        step_a(32'd100,        1'b1, 2'b01, "clamp_100_hold");

        // Mid-operation reset from OVERBOUGHT
        step_a(32'd100, 1'b0, 2'b00, "mid_rst_a");
        step_a(32'd50,  1'b1, 2'b00, "post_rst_a_50");

        // Persistence, CONFIRM=3
        step_b(32'd10, 1'b0, 2'b00, "b_rst");
        step_b(32'd20, 1'b1, 2'b00, "p_20_1");
        step_b(32'd20, 1'b1, 2'b00, "p_20_2");
        step_b(32'd50, 1'b1, 2'b00, "p_50_break");
        step_b(32'd20, 1'b1, 2'b00, "p_20_3");
        step_b(32'd20, 1'b1, 2'b00, "p_20_4");
        step_b(32'd20, 1'b1, 2'b10, "p_20_5_enter");

        // Into OVERBOUGHT, exit OVERSOLD without filter
        step_b(32'd80, 1'b1, 2'b00, "p_80_1");
        step_b(32'd80, 1'b1, 2'b00, "p_80_2");
        step_b(32'd80, 1'b1, 2'b01, "p_80_3");

        // Mid-operation reset restarts qualification
        step_b(32'd80, 1'b0, 2'b00, "b_mid_rst");
        step_b(32'd80, 1'b1, 2'b00, "b_rel_1");
        step_b(32'd80, 1'b1, 2'b00, "b_rel_2");
        step_b(32'd80, 1'b1, 2'b01, "b_rel_3");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rsi_signal.md
# rsi_signal

Threshold detector for a Relative Strength Index stream in the trading-signal datapath. Each clock it compares a precomputed RSI value, on a 0–100 integer scale, against oversold and overbought thresholds with hysteresis and a persistence filter. It drives two registered, mutually exclusive flags: out1 (oversold/buy) and out2 (overbought/sell). It sits directly downstream of the RSI calculator and feeds order-decision logic.

## Interface
- WIDTH, 32: RSI input width.
- LOW_TH, 30: oversold entry threshold; entry condition is RSI < LOW_TH.
- HIGH_TH, 70: overbought entry threshold; entry condition is RSI > HIGH_TH.
- HYST, 2: exit hysteresis band.
- CONFIRM, 1: consecutive qualifying cycles required before a flag asserts; must be ≥1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- RSI  in  WIDTH  unsigned RSI sample, taken every cycle.
- out1  out  1  oversold flag (buy).
- out2  out  1  overbought flag (sell).

## Operation
- Clamp: r = min(RSI, 100). All comparisons use r. Comparisons are unsigned at full WIDTH, with no truncation.
- Persistence counters:
  - cnt_lo increments while r < LOW_TH and saturates at CONFIRM; it clears to 0 on any cycle where r ≥ LOW_TH.
  - cnt_hi does the same for r > HIGH_TH.
  - lo_ok means the next value of cnt_lo equals CONFIRM; hi_ok is defined the same way for cnt_hi.
- States are NEUTRAL, OVERSOLD and OVERBOUGHT. out1 = (state == OVERSOLD) and out2 = (state == OVERBOUGHT), so both flags are never high together.
- Transitions, with priority in the order listed:
  - NEUTRAL: lo_ok → OVERSOLD; otherwise hi_ok → OVERBOUGHT; otherwise stay.
  - OVERSOLD: hi_ok → OVERBOUGHT; otherwise r ≥ LOW_TH+HYST → NEUTRAL; otherwise stay. Values in [LOW_TH, LOW_TH+HYST) hold the state.
  - OVERBOUGHT: lo_ok → OVERSOLD; otherwise r ≤ HIGH_TH−HYST → NEUTRAL; otherwise stay.
- Elaboration-time checks, which must fail elaboration if violated:
  - LOW_TH + HYST ≤ HIGH_TH − HYST
  - HIGH_TH ≤ 100
  - CONFIRM ≥ 1
- Boundary values:
  - r = LOW_TH is not oversold.
  - r = HIGH_TH is not overbought.
  - RSI values above 100, including 0xFFFFFFFF, behave as 100 and therefore qualify as overbought.

## Timing
- Reset: on any rising edge with rst_n = 0, state becomes NEUTRAL, both counters become 0, and out1 = out2 = 0. Reset has priority over all other logic, including reset asserted mid-qualification.
- Entry latency: a flag asserts on the CONFIRM-th consecutive qualifying edge. With CONFIRM = 1, the flag is high one edge after the qualifying RSI is presented.
- Exit latency: one edge, with no persistence filter.
- A direct swing from r < LOW_TH to r > HIGH_TH, with CONFIRM = 1, moves OVERSOLD → OVERBOUGHT in one edge with no NEUTRAL cycle in between.
- A single non-qualifying sample resets the corresponding counter, so qualification starts over.
- Outputs are registered only; there is no combinational path from RSI to out1 or out2.

## Structure
- Package rsi_pkg contains:
  - the state enum {NEUTRAL, OVERSOLD, OVERBOUGHT};
  - RSI_MAX = 100;
  - default threshold constants.
- Sub-module rsi_persist is a saturating consecutive-condition counter with parameter CONFIRM. It has inputs clk, rst_n and cond, and output ok, which is the next-state saturated indication. It is instantiated twice, once for the low condition and once for the high condition.
- The top level holds the clamp, the comparators and the three-state FSM.

## Test plan
- Reset: hold rst_n = 0 for 2 edges with RSI = 10 → out1 = 0, out2 = 0. Release reset → out1 = 1 after 1 edge.
- Thresholds (defaults): present RSI = 29, 30, 50, 70, 71 in turn → (out1, out2) = (1,0), (1,0) held by hysteresis, (0,0), (0,0), (0,1).
- Hysteresis: from OVERSOLD, RSI = 31 → out1 stays 1; RSI = 32 → out1 = 0. From OVERBOUGHT, RSI = 69 → out2 stays 1; RSI = 68 → out2 = 0.
- Swing and clamp: RSI = 5 then 0xFFFFFFFF → out1 = 1, then on the next edge out1 = 0 and out2 = 1 with no idle cycle. Also check RSI = 101 → out2 = 1.
- Persistence (CONFIRM = 3): RSI sequence 20, 20, 50, 20, 20, 20 → out1 rises only after the sixth sample's edge.
- Mid-operation reset: while in OVERBOUGHT, assert rst_n = 0 for 1 edge → out2 = 0 immediately. Release with RSI = 80 and CONFIRM = 3 → out2 re-asserts 3 edges later.
